// File: rtl/fp_align_cal_pipe.sv
// fp_align_cal_pipe: registered hand-off from the FP align stage to the calc stage.
// Define FP_PIPE_SKID_EN to build the skid register and a fully registered in_ready.
module fp_align_cal_pipe #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_rm,
  input  logic [3:0]          in_flags,
  input  logic [FRAC_W-1:0]   in_inf_nan_frac,
  input  logic [EXP_W-1:0]    in_exp,
  input  logic [FRAC_W:0]     in_large_frac,
  input  logic [FRAC_W+3:0]   in_small_frac,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          out_rm,
  output logic [3:0]          out_flags,
  output logic [FRAC_W-1:0]   out_inf_nan_frac,
  output logic [EXP_W-1:0]    out_exp,
  output logic [FRAC_W:0]     out_large_frac,
  output logic [FRAC_W+3:0]   out_small_frac,
  output logic [15:0]         stall_cnt
);
  localparam int PW = 3*FRAC_W + EXP_W + 11;
  logic [PW-1:0] in_d, main_q;
  logic acc, drn;
  assign in_d = {in_rm, in_flags, in_inf_nan_frac, in_exp, in_large_frac, in_small_frac};
  assign {out_rm, out_flags, out_inf_nan_frac, out_exp, out_large_frac, out_small_frac} = main_q;
  assign acc = in_valid & in_ready;
  assign drn = out_valid & out_ready;
`ifdef FP_PIPE_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q;
  logic [PW-1:0] skid_q;
  logic in_ready_q;
  assign in_ready = in_ready_q;
  assign out_valid = state_q != EMPTY;
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= EMPTY;
      in_ready_q <= 1'b1;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: if (acc) begin
          main_q <= in_d;
          state_q <= ONE;
        end
        ONE: if (acc && drn) main_q <= in_d;
          else if (drn) state_q <= EMPTY;
          else if (acc) begin
            skid_q <= in_d;
            state_q <= FULL;
            in_ready_q <= 1'b0;
          end
        FULL: if (drn) begin
          main_q <= skid_q;
          state_q <= ONE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end
`else
  typedef enum logic {EMPTY, ONE} state_t;
  state_t state_q;
  // Without a skid slot the main register may only refill in the cycle it drains.
  assign in_ready = ~out_valid | out_ready;
  assign out_valid = state_q != EMPTY;
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= EMPTY;
      main_q <= '0;
    end else if (flush) state_q <= EMPTY;
    else if (acc) begin
      main_q <= in_d;
      state_q <= ONE;
    end else if (drn) state_q <= EMPTY;
  end
`endif
  always_ff @(posedge clk) begin
    if (clr) stall_cnt <= '0;
    else if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 16'd1;
  end
endmodule
